// File: rtl/tiny_cpu_core.sv
// Multi-cycle 4-register CPU core with a valid/ready instruction stream.
// Define TINY_CPU_BRANCH_EN to enable JMP/JZ; otherwise they act as two-word NOPs.
module tiny_cpu_core #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic [1:0]        flags,
    output logic [1:0]        state,
    output logic              halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_IMM   = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_SHL  = 4'h8;
    localparam logic [3:0] OP_SHR  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_OUT  = 4'hD;
    localparam logic [3:0] OP_CMP  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [7:0]          r_ir;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_regs [4];
    logic                r_z;
    logic                r_c;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;

    logic [3:0]          w_op;
    logic [1:0]          w_rd;
    logic [1:0]          w_rs;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_sumi;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_res;
    logic                w_c;
    logic                w_z;
    logic                w_rd_we;
    logic                w_flag_we;
    logic                w_in_two;

    function automatic logic is_two(input logic [3:0] op);
        case (op)
            OP_LDI, OP_ADDI, OP_JMP, OP_JZ: is_two = 1'b1;
            default:                        is_two = 1'b0;
        endcase
    endfunction

    assign w_op     = r_ir[7:4];
    assign w_rd     = r_ir[3:2];
    assign w_rs     = r_ir[1:0];
    assign w_a      = r_regs[w_rd];
    assign w_b      = r_regs[w_rs];
    assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
    assign w_sumi   = {1'b0, w_a} + {1'b0, r_imm};
    assign w_diff   = {1'b0, w_a} - {1'b0, w_b};
    assign w_z      = (w_res == '0);
    assign w_in_two = is_two(in_data[7:4]);

`ifdef TINY_CPU_BRANCH_EN
    logic            w_jump;
    logic [PC_W-1:0] w_target;

    assign w_target = PC_W'(r_imm);
    assign w_jump   = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_z);
`endif

    always_comb begin
        w_res     = '0;
        w_c       = r_c;
        w_rd_we   = 1'b0;
        w_flag_we = 1'b0;
        case (w_op)
            OP_LDI: begin
                w_res   = r_imm;
                w_rd_we = 1'b1;
            end
            OP_MOV: begin
                w_res   = w_b;
                w_rd_we = 1'b1;
            end
            OP_ADD: begin
                w_res     = w_sum[DATA_W-1:0];
                w_c       = w_sum[DATA_W];
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_SUB: begin
                w_res     = w_diff[DATA_W-1:0];
                w_c       = w_diff[DATA_W];
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_AND: begin
                w_res     = w_a & w_b;
                w_c       = 1'b0;
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_OR: begin
                w_res     = w_a | w_b;
                w_c       = 1'b0;
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_XOR: begin
                w_res     = w_a ^ w_b;
                w_c       = 1'b0;
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_SHL: begin
                w_res     = {w_a[DATA_W-2:0], 1'b0};
                w_c       = w_a[DATA_W-1];
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_SHR: begin
                w_res     = {1'b0, w_a[DATA_W-1:1]};
                w_c       = w_a[0];
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_ADDI: begin
                w_res     = w_sumi[DATA_W-1:0];
                w_c       = w_sumi[DATA_W];
                w_rd_we   = 1'b1;
                w_flag_we = 1'b1;
            end
            OP_CMP: begin
                w_res     = w_diff[DATA_W-1:0];
                w_c       = w_diff[DATA_W];
                w_flag_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FETCH: begin
                if (in_valid) w_state_nxt = w_in_two ? ST_IMM : ST_EXEC;
            end
            ST_IMM: begin
                if (in_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = (w_op == OP_HLT) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: w_state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_FETCH;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_ir        <= '0;
            r_imm       <= '0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (in_valid) begin
                        r_ir <= in_data[7:0];
                        r_pc <= r_pc + 1'b1;
                    end
                end
                ST_IMM: begin
                    if (in_valid) begin
                        r_imm <= in_data;
                        r_pc  <= r_pc + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (w_rd_we) r_regs[w_rd] <= w_res;
                    if (w_flag_we) begin
                        r_z <= w_z;
                        r_c <= w_c;
                    end
                    if (w_op == OP_OUT) begin
                        r_out_data  <= w_b;
                        r_out_valid <= 1'b1;
                    end
`ifdef TINY_CPU_BRANCH_EN
                    // No increment happens in EXEC, so the jump owns pc here.
                    if (w_jump) r_pc <= w_target;
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_FETCH) || (r_state == ST_IMM);
    assign halted    = (r_state == ST_HALT);
    assign state     = r_state;
    assign pc        = r_pc;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign flags     = {r_c, r_z};

endmodule

// File: tb/tb_tiny_cpu_core.sv
// Directed bench for tiny_cpu_core with hand-computed expectations.
// JZ/JMP expectations follow TINY_CPU_BRANCH_EN.
module tb_tiny_cpu_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] pc;
    logic [7:0] out_data;
    logic       out_valid;
    logic [1:0] flags;
    logic [1:0] state;
    logic       halted;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int c0   = 0;

    tiny_cpu_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .pc       (pc),
        .out_data (out_data),
        .out_valid(out_valid),
        .flags    (flags),
        .state    (state),
        .halted   (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] w);
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic exec_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic op1(input logic [7:0] w);
        send(w);
        exec_edge();
    endtask

    task automatic op2(input logic [7:0] w, input logic [7:0] imm);
        send(w);
        send(imm);
        exec_edge();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_state"}, state, 0);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_flags"}, flags, 0);
        check({tag, "_odata"}, out_data, 0);
        check({tag, "_ovalid"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] exp_pc;

        #1;
        check_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Program 1: 5 + 3, streamed back-to-back
        send(8'h10);
        c0 = cyc;
        send(8'h05);
        exec_edge();
        op2(8'h14, 8'h03);
        op1(8'h31);
        op1(8'hD0);
        check("p1_odata", out_data, 8'h08);
        check("p1_ovalid", out_valid, 1);
        check("p1_flags", flags, 2'b00);
        check("p1_cycle", cyc - c0, 9);
        check("p1_pc", pc, 6);
        exec_edge();
        check("p1_ovalid_drop", out_valid, 0);
        check("p1_odata_hold", out_data, 8'h08);
        check("p1_idle_state", state, 0);
        check("p1_idle_pc", pc, 6);

        // Carry/zero and borrow
        op2(8'h10, 8'hFF);
        op2(8'h14, 8'h01);
        op1(8'h31);
        check("add_wrap_flags", flags, 2'b11);
        op1(8'hD0);
        check("add_wrap_r0", out_data, 8'h00);
        op1(8'h41);
        check("sub_borrow_flags", flags, 2'b10);
        op1(8'hD0);
        check("sub_borrow_r0", out_data, 8'hFF);
        op1(8'h70);
        check("xor_self_flags", flags, 2'b01);

        // Shifts, ADDI, MOV
        op2(8'h18, 8'h81);
        op1(8'h88);
        check("shl_flags", flags, 2'b10);
        op1(8'hD2);
        check("shl_r2", out_data, 8'h02);
        op1(8'h98);
        check("shr_flags", flags, 2'b00);
        op2(8'hA8, 8'hFF);
        check("addi_flags", flags, 2'b11);
        op1(8'h2D);
        op1(8'hD3);
        check("mov_r3", out_data, 8'h01);
        check("mov_flags_keep", flags, 2'b11);
        check("p2_pc", pc, 24);

        // Logic ops
        op2(8'h10, 8'h0C);
        op2(8'h14, 8'h0A);
        op1(8'h51);
        check("and_flags", flags, 2'b00);
        op1(8'hD0);
        check("and_r0", out_data, 8'h08);
        op1(8'h61);
        op1(8'hD0);
        check("or_r0", out_data, 8'h0A);

        // Stall between LDI word and its immediate
        send(8'h1C);
        for (int i = 0; i < 3; i++) begin
            exec_edge();
            check("stall_state", state, 2'b01);
            check("stall_pc", pc, 33);
        end
        send(8'h5A);
        exec_edge();
        op1(8'hD3);
        check("stall_r3", out_data, 8'h5A);
        check("stall_pc_end", pc, 35);

        // CMP then JZ, then JMP
        op1(8'hEA);
        check("cmp_flags", flags, 2'b01);
        check("cmp_pc", pc, 36);
        op2(8'hC0, 8'h40);
`ifdef TINY_CPU_BRANCH_EN
        exp_pc = 8'h40;
`else
        exp_pc = 8'd38;
`endif
        check("jz_pc", pc, exp_pc);
        op2(8'hB0, 8'h20);
`ifdef TINY_CPU_BRANCH_EN
        exp_pc = 8'h20;
`else
        exp_pc = 8'd40;
`endif
        check("jmp_pc", pc, exp_pc);

        // Halt and stay halted with input offered
        op1(8'hF0);
        exp_pc = exp_pc + 8'd1;
        check("hlt_state", state, 2'b11);
        check("hlt_halted", halted, 1);
        check("hlt_ready", in_ready, 0);
        @(negedge clk);
        in_data  = 8'h10;
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hlt_stay", halted, 1);
        check("hlt_pc_hold", pc, exp_pc);
        check("hlt_ready_stay", in_ready, 0);

        // Later run, then reset mid-IMM
        pulse_reset();
        op2(8'h10, 8'h33);
        op1(8'hD0);
        check("run2_r0", out_data, 8'h33);
        op2(8'h14, 8'h40);
        op1(8'hE1);
        check("run2_cmp_flags", flags, 2'b10);
        check("run2_pc", pc, 6);
        send(8'h10);
        check("run2_imm_state", state, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        op1(8'hD0);
        check("post_rst_r0", out_data, 8'h00);
        check("post_rst_ovalid", out_valid, 1);

        // pc wrap after 256 NOPs
        pulse_reset();
        repeat (255) op1(8'h00);
        check("wrap_pc_max", pc, 8'hFF);
        op1(8'h00);
        check("wrap_pc_zero", pc, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/tiny_cpu_core.md
# tiny_cpu_core

Parametrised multi-cycle accumulator-less CPU core. It is the next generation of the team's 8-bit Tiny Tapeout CPU: configurable data and PC width, four general registers, a valid/ready instruction stream, two-word immediates, Z/C flags, optional branches, a strobed output port and a halt state. It sits behind the tt_um wrapper. `in_*` is driven from `ui_in`, and `pc`/`state` are mirrored on `uio_out`.

## Interface
- `DATA_W`, default 8: datapath, register and immediate width; must be ≥ 8.
- `PC_W`, default 8: program counter width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  `DATA_W`  instruction word (bits [7:0]) or immediate word (all bits).
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  core accepts `in_data` this cycle.
- `pc`  out  `PC_W`  address of next word to supply.
- `out_data`  out  `DATA_W`  output port register.
- `out_valid`  out  1  one-cycle strobe, `out_data` updated.
- `flags`  out  2  {C, Z}.
- `state`  out  2  FSM state code.
- `halted`  out  1  core in HALT.

## Operation
- Instruction word is `{op[3:0], rd[1:0], rs[1:0]}`; registers R0–R3.
- Opcodes:
  - 0 NOP.
  - 1 LDI rd←imm.
  - 2 MOV rd←rs.
  - 3 ADD rd←rd+rs.
  - 4 SUB rd←rd−rs.
  - 5 AND, 6 OR, 7 XOR (rd←rd op rs).
  - 8 SHL rd←rd<<1, C←old msb.
  - 9 SHR rd←rd>>1 logical, C←old lsb.
  - A ADDI rd←rd+imm.
  - B JMP pc←imm[PC_W-1:0].
  - C JZ: if Z then pc←imm.
  - D OUT out_data←rs.
  - E CMP: flags from rd−rs, no write.
  - F HLT.
- Two-word ops (1, A, B, C) fetch an immediate word after the instruction.
- FSM states, with `state` codes:
  - FETCH=00: `in_ready`=1. On `in_valid`, latch IR and pc←pc+1. Go to IMM if two-word, else EXEC.
  - IMM=01: `in_ready`=1. On `in_valid`, latch imm, pc←pc+1, go to EXEC.
  - EXEC=10: execute and write back in this one cycle, then go to FETCH. HLT goes to HALT.
  - HALT=11: `in_ready`=0, `halted`=1. Stays until reset.
- Arithmetic:
  - Modulo 2^DATA_W.
  - ADD/ADDI: C=carry-out.
  - SUB/CMP: C=borrow (1 when rd<rs unsigned).
  - Z=(result==0) for ops 3–A and E. Logic ops clear C.
  - MOV, LDI, OUT, jumps and NOP leave flags unchanged.
- `pc` wraps 2^PC_W−1 → 0. A jump write in EXEC takes priority, because no increment occurs in EXEC.
- `in_valid` low in FETCH or IMM: the core waits, nothing changes.
- Reset mid-operation: every register returns to its reset value immediately, and any partly fetched instruction is discarded.

## Timing
- Reset values: pc=0, R0–R3=0, flags=00, out_data=0, out_valid=0, state=FETCH, halted=0. `in_ready`=1 (combinational from state).
- Latency with no stalls: one-word instruction 2 cycles (FETCH, EXEC); two-word instruction 3 cycles.
- Register, flag, pc and out_data updates are visible the cycle after EXEC.
- `out_valid` is high for exactly the one cycle following the OUT EXEC edge. `out_data` holds until the next OUT.
- Each input stall cycle adds exactly one cycle of latency.

## Configuration
- `TINY_CPU_BRANCH_EN`:
  - Defined: JMP/JZ behave as specified.
  - Undefined: ops B/C still consume their immediate word and take 3 cycles, but pc is unchanged beyond the normal increments (they execute as two-word NOPs).

## Test plan
- Reset, then stream LDI R0,0x05; LDI R1,0x03; ADD R0,R1; OUT R0 → `out_data`=0x08, `out_valid` one cycle, Z=0 C=0, OUT strobe at cycle 9 after the first accept.
- LDI R0,0xFF; LDI R1,0x01; ADD R0,R1 → R0=0x00, Z=1, C=1. Then SUB R0,R1 → R0=0xFF, C=1, Z=0.
- Drop `in_valid` for 3 cycles between the instruction and immediate of LDI → `pc` and `state` hold at IMM, then LDI completes correctly.
- CMP R2,R2 then JZ 0x40 (macro defined) → `pc`=0x40 after EXEC. Same with the macro undefined → `pc`=previous+2.
- `PC_W`=4, 16 NOPs from reset → `pc` wraps 15→0.
- HLT → `halted`=1, `in_ready`=0 indefinitely. Assert `rst_n` mid-IMM of a later run → all outputs return to reset values asynchronously.
